// File: rtl/e17_out_packer.sv
// Change-capture FIFO for the e17 controller outputs: timestamps each new vector and queues it.
// Optional E17_PACK_PARITY_EN adds a stored even-parity MSB to every queued word.
module e17_out_packer #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [16:0]             y_in,
    input  logic                    y_vld,
`ifdef E17_PACK_PARITY_EN
    output logic [TS_W+17:0]        out_data,
`else
    output logic [TS_W+16:0]        out_data,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = TS_W + 17;
`ifdef E17_PACK_PARITY_EN
    localparam int WW = PW + 1;
`else
    localparam int WW = PW;
`endif

    logic [WW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [LW-1:0]   level;
    logic [TS_W-1:0] ts;
    logic [16:0]     last_vec;
    logic [PW-1:0]   word;
    logic            chg, full, pop, push, drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [WW-1:0] pack_word(input logic [PW-1:0] w);
`ifdef E17_PACK_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    // A sample taken during reset never counts as an event.
    assign chg  = !rst && y_vld && (y_in != last_vec);
    assign full = (level == LW'(DEPTH));
    assign pop  = out_valid && out_ready;
    assign push = chg && (!full || pop);
    assign drop = chg && full && !pop;
    assign word = {ts, y_in};

    assign out_valid  = (level != '0);
    assign out_data   = mem[rptr];
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts       <= '0;
            last_vec <= '0;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            drop_cnt <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (y_vld)
                last_vec <= y_in;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (drop)
                drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    // Storage is data only and is left unreset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= pack_word(word);
    end

endmodule

// File: tb/tb_e17_out_packer.sv
// Bench for e17_out_packer: vector table plus corner-case sequences, checked against a queue scoreboard.
module tb_e17_out_packer;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;
`ifdef E17_PACK_PARITY_EN
    localparam int OW = TS_W + 18;
`else
    localparam int OW = TS_W + 17;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [16:0]   y_in = '0;
    logic          y_vld = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    fifo_level;
    logic [7:0]    drop_cnt;

    e17_out_packer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst(rst), .y_in(y_in), .y_vld(y_vld),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [OW-1:0] q[$];
    logic [16:0]   lv_m;
    logic [7:0]    ts_m;
    int            drops_m;

    typedef struct {
        logic        r;
        logic        v;
        logic [16:0] y;
        logic        rd;
        int          lvl;
        int          drp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [OW-1:0] mkword(input logic [7:0] t, input logic [16:0] y);
`ifdef E17_PACK_PARITY_EN
        return {^{t, y}, t, y};
`else
        return {t, y};
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, update the model, then compare after the edge.
    task automatic cyc(input logic r, input logic v, input logic [16:0] y, input logic rd);
        rst = r; y_vld = v; y_in = y; out_ready = rd;
        if (!r) begin
            if (rd && q.size() > 0) begin
                chk("pop_data", 64'(out_data), 64'(q[0]));
                void'(q.pop_front());
            end
            if (v && y != lv_m) begin
                if (q.size() < DEPTH) q.push_back(mkword(ts_m, y));
                else if (drops_m < 255) drops_m++;
            end
            if (v) lv_m = y;
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete(); lv_m = '0; drops_m = 0; ts_m = '0;
        end else begin
            ts_m = ts_m + 8'd1;
        end
        chk("level", 64'(fifo_level), 64'(q.size()));
        chk("valid", 64'(out_valid), 64'(q.size() != 0));
        chk("drop", 64'(drop_cnt), 64'(drops_m));
        if (q.size() != 0) chk("head", 64'(out_data), 64'(q[0]));
    endtask

    task automatic row(input logic r, input logic v, input logic [16:0] y, input logic rd,
                       input int lvl, input int drp);
        vec_t e;
        e.r = r; e.v = v; e.y = y; e.rd = rd; e.lvl = lvl; e.drp = drp;
        tbl.push_back(e);
    endtask

    initial begin
        lv_m = '0; ts_m = '0; drops_m = 0;

        row(1, 0, 17'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) row(0, 1, 17'h0, 0, 0, 0);
        row(0, 0, 17'h0, 0, 0, 0);
        row(0, 0, 17'h0, 0, 0, 0);
        row(0, 1, 17'h00142, 0, 1, 0);
        row(0, 1, 17'h00142, 0, 1, 0);
        row(1, 0, 17'h0, 0, 0, 0);
        row(0, 1, 17'h1, 0, 1, 0);
        row(0, 1, 17'h2, 0, 2, 0);
        row(0, 1, 17'h3, 0, 3, 0);
        row(0, 1, 17'h4, 0, 4, 0);
        row(0, 1, 17'h5, 0, 4, 1);
        row(0, 0, 17'h0, 1, 3, 1);
        row(0, 0, 17'h0, 1, 2, 1);
        row(0, 0, 17'h0, 1, 1, 1);
        row(0, 0, 17'h0, 1, 0, 1);
        row(0, 1, 17'h6, 0, 1, 1);
        row(0, 1, 17'h7, 0, 2, 1);
        row(0, 1, 17'h0, 0, 3, 1);
        row(0, 1, 17'h9, 0, 4, 1);
        row(0, 1, 17'hA, 1, 4, 1);
        row(0, 0, 17'h0, 1, 3, 1);
        row(0, 0, 17'h0, 1, 2, 1);
        row(0, 0, 17'h0, 1, 1, 1);
        row(0, 0, 17'h0, 1, 0, 1);
        row(0, 1, 17'h1FFFF, 1, 1, 1);
        row(0, 0, 17'h0, 1, 0, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].v, tbl[i].y, tbl[i].rd);
            chk("tbl_level", 64'(fifo_level), 64'(tbl[i].lvl));
            chk("tbl_drop", 64'(drop_cnt), 64'(tbl[i].drp));
            chk("tbl_valid", 64'(out_valid), 64'(tbl[i].lvl != 0));
            if (i == 6) chk("first_word", 64'(out_data[TS_W+16:0]), {39'd0, 8'd5, 17'h00142});
        end

        // Saturating drop counter.
        cyc(1, 0, 17'h0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 1, 17'(i), 0);
        for (int i = 0; i < 300; i++) cyc(0, 1, (i % 2) ? 17'h100 : 17'h200, 0);
        chk("drop_sat", 64'(drop_cnt), 64'd255);
        cyc(0, 1, 17'h300, 0);
        chk("drop_hold", 64'(drop_cnt), 64'd255);

        // Reset with three words queued; the reset-cycle sample is ignored.
        cyc(0, 0, 17'h0, 1);
        cyc(0, 0, 17'h0, 1);
        cyc(0, 1, 17'h55, 0);
        chk("pre_rst_level", 64'(fifo_level), 64'd3);
        cyc(1, 1, 17'h77, 0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        cyc(0, 1, 17'h0, 0);
        chk("rst_lastvec", 64'(fifo_level), 64'd0);

        // Timestamp wrap.
        cyc(1, 0, 17'h0, 0);
        while (ts_m != 8'd255) cyc(0, 0, 17'h0, 0);
        cyc(0, 1, 17'hA, 0);
        cyc(0, 1, 17'hB, 0);
        chk("ts_wrap_a", 64'(out_data[TS_W+16:17]), 64'd255);
        cyc(0, 0, 17'h0, 1);
        chk("ts_wrap_b", 64'(out_data[TS_W+16:17]), 64'd0);
        cyc(0, 0, 17'h0, 1);

`ifdef E17_PACK_PARITY_EN
        cyc(1, 0, 17'h0, 0);
        cyc(0, 1, 17'h00001, 0);
        chk("parity_msb", 64'(out_data[OW-1]), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
